// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// length decoding and the checksum target value.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WR,
        CHK,
        DONE,
        ERR
    } loaderState_t;

    localparam logic [8:0] LEN_ZERO_WORDS = 9'd256;
    localparam logic [7:0] CHK_GOOD       = 8'h00;

    // A length byte of zero stands for a full 256-word program.
    function automatic logic [8:0] lenToWords(input logic [7:0] lenByte);
        return (lenByte == 8'd0) ? LEN_ZERO_WORDS : {1'b0, lenByte};
    endfunction

endpackage

// File: rtl/loader_sum8.sv
// Clear/accumulate 8-bit modular adder used to build the running checksum of
// the program data bytes.
module loader_sum8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       accumulate,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= 8'h00;
        end else if (accumulate) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a host byte stream into big-endian 16-bit
// words, writes them to IMEM and releases the core once the program is in.
// Build option IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte check.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [8:0]        words_loaded
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    loaderState_t state;
    loaderState_t nextState;

    logic [8:0] targetWords;
    logic [8:0] wordsLoaded;
    logic [7:0] hiByte;
    logic       idleLike;
    logic       startAccepted;
    logic       lastWord;

    assign idleLike      = (state == IDLE) || (state == DONE) || (state == ERR);
    assign startAccepted = start && idleLike;
    assign lastWord      = ((wordsLoaded + 9'd1) == targetWords);
    assign words_loaded  = wordsLoaded;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] runningSum;
    logic [7:0] checkTotal;
    logic       sumAccumulate;

    assign sumAccumulate = ((state == HI) || (state == LO)) && in_valid;
    assign checkTotal    = runningSum + in_data;

    loader_sum8 u_sum (
        .clk        (clk),
        .rst        (rst),
        .clear      (startAccepted),
        .accumulate (sumAccumulate),
        .data       (in_data),
        .sum        (runningSum)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE, ERR: if (startAccepted) nextState = LEN;
            LEN:             if (in_valid) nextState = HI;
            HI:              if (in_valid) nextState = LO;
            LO:              if (in_valid) nextState = WR;
            WR: begin
                if (lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    nextState = CHK;
`else
                    nextState = DONE;
`endif
                end else begin
                    nextState = HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (in_valid) nextState = (checkTotal == CHK_GOOD) ? DONE : ERR;
`else
            CHK: nextState = IDLE;
`endif
            default: nextState = IDLE;
        endcase
    end

    // Status flags follow the state directly so done/cpu_hold change on the
    // same edge that enters DONE.
    always_comb begin
        in_ready = (state == LEN) || (state == HI) || (state == LO) || (state == CHK);
        mem_we   = (state == WR);
        busy     = !idleLike;
        done     = (state == DONE);
        cpu_hold = (state != DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        error    = (state == ERR);
`else
        error    = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= BASE;
            mem_wdata   <= 16'h0000;
            wordsLoaded <= 9'd0;
            targetWords <= 9'd0;
            hiByte      <= 8'h00;
        end else begin
            if (startAccepted) begin
                mem_addr    <= BASE;
                wordsLoaded <= 9'd0;
            end
            if ((state == LEN) && in_valid) begin
                targetWords <= lenToWords(in_data);
            end
            if ((state == HI) && in_valid) begin
                hiByte <= in_data;
            end
            if ((state == LO) && in_valid) begin
                mem_wdata <= {hiByte, in_data};
            end
            if (state == WR) begin
                mem_addr    <= mem_addr + 1'b1;
                wordsLoaded <= wordsLoaded + 9'd1;
            end
        end
    end

endmodule
